// File: rtl/arm_pkg.sv
// Shared definitions for the multi-cycle ARM32 core: condition codes,
// opcodes, shift types, FSM states and instruction field positions.
package arm_pkg;

   localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                          COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                          COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                          COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                          OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                          OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                          OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

   localparam logic [1:0] SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3;

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   // Field positions (LSB of multi-bit fields)
   localparam int F_COND = 28;
   localparam int F_RN   = 16;
   localparam int F_RD   = 12;
   localparam int F_RM   = 0;
   localparam int B_I    = 25;
   localparam int B_P    = 24;
   localparam int B_U    = 23;
   localparam int B_B    = 22;
   localparam int B_W    = 21;
   localparam int B_L    = 20;
   localparam int B_S    = 20;
   localparam int B_LINK = 24;
   localparam int B_REGSH = 4;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] k);
      return (x >> k) | (x << (6'd32 - {1'b0, k}));
   endfunction

   // nzcv = {N, Z, C, V}
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, r;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: r = z;
         COND_NE: r = !z;
         COND_CS: r = c;
         COND_CC: r = !c;
         COND_MI: r = n;
         COND_PL: r = !n;
         COND_VS: r = v;
         COND_VC: r = !v;
         COND_HI: r = c && !z;
         COND_LS: r = !c || z;
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = !z && (n == v);
         COND_LE: r = z || (n != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/arm_alu.sv
// Combinational operand-2 barrel shifter, 16-opcode ALU and NZCV generation.
module arm_alu
   import arm_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic        imm_op,
   input  logic [7:0]  imm8,
   input  logic [6:0]  shift_field,   // ir[11:5]: rot in [6:3], amount in [6:2], type in [1:0]
   input  logic [31:0] rn_val,
   input  logic [31:0] rm_val,
   input  logic        c_in,
   input  logic        v_in,
   output logic [31:0] result,
   output logic [3:0]  nzcv_out
);

   logic [3:0]  rot;
   logic [4:0]  amt;
   logic [1:0]  sh_type;
   logic [31:0] sh_val;
   logic        sh_c;
   logic [32:0] tmp33;
   logic [31:0] a, b;
   logic        cin, arith;
   logic [32:0] sum;

   assign rot     = shift_field[6:3];
   assign amt     = shift_field[6:2];
   assign sh_type = shift_field[1:0];

   // Operand 2: rotated immediate or immediate-shifted Rm, with shifter carry-out
   always_comb begin
      sh_val = rm_val;
      sh_c   = c_in;
      tmp33  = '0;
      if (imm_op) begin
         sh_val = ror32({24'd0, imm8}, {rot, 1'b0});
         if (rot != 4'd0) sh_c = sh_val[31];
      end else begin
         case (sh_type)
            SH_LSL: begin
               if (amt != 5'd0) begin
                  tmp33  = {1'b0, rm_val} << amt;
                  sh_val = tmp33[31:0];
                  sh_c   = tmp33[32];
               end
            end
            SH_LSR: begin
               if (amt == 5'd0) begin
                  sh_val = '0;
                  sh_c   = rm_val[31];
               end else begin
                  tmp33  = {rm_val, 1'b0} >> amt;
                  sh_val = tmp33[32:1];
                  sh_c   = tmp33[0];
               end
            end
            SH_ASR: begin
               if (amt == 5'd0) begin
                  sh_val = {32{rm_val[31]}};
                  sh_c   = rm_val[31];
               end else begin
                  tmp33  = $signed({rm_val, 1'b0}) >>> amt;
                  sh_val = tmp33[32:1];
                  sh_c   = tmp33[0];
               end
            end
            default: begin
               if (amt == 5'd0) begin
                  sh_val = {c_in, rm_val[31:1]};
                  sh_c   = rm_val[0];
               end else begin
                  sh_val = ror32(rm_val, amt);
                  sh_c   = sh_val[31];
               end
            end
         endcase
      end
   end

   // ALU: arithmetic ops share one adder with optional operand inversion
   always_comb begin
      a     = rn_val;
      b     = sh_val;
      cin   = 1'b0;
      arith = 1'b1;
      case (opcode)
         OP_SUB, OP_CMP: begin b = ~sh_val; cin = 1'b1; end
         OP_RSB:         begin a = sh_val; b = ~rn_val; cin = 1'b1; end
         OP_ADD, OP_CMN: ;
         OP_ADC:         cin = c_in;
         OP_SBC:         begin b = ~sh_val; cin = c_in; end
         OP_RSC:         begin a = sh_val; b = ~rn_val; cin = c_in; end
         default:        arith = 1'b0;
      endcase
      sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      case (opcode)
         OP_AND, OP_TST: result = rn_val & sh_val;
         OP_EOR, OP_TEQ: result = rn_val ^ sh_val;
         OP_ORR:         result = rn_val | sh_val;
         OP_MOV:         result = sh_val;
         OP_BIC:         result = rn_val & ~sh_val;
         OP_MVN:         result = ~sh_val;
         default:        result = sum[31:0];
      endcase
      nzcv_out[3] = result[31];
      nzcv_out[2] = (result == 32'd0);
      nzcv_out[1] = arith ? sum[32] : sh_c;
      nzcv_out[0] = arith ? ((a[31] == b[31]) && (sum[31] != a[31])) : v_in;
   end

endmodule

// File: rtl/arm_mc_core.sv
// Multi-cycle ARM32 integer-subset core with stallable fetch and data ports.
//
// state | meaning
// FETCH | wait for inst_valid, latch instruction into IR
// EXEC  | condition check, execute DP/branch, compute load/store address
// MEM   | hold data strobes until mem_ready, then retire the access
// HALT  | unsupported encoding seen; left only by reset
module arm_mc_core
   import arm_pkg::*;
#(
   parameter int          ARCH          = 32,
   parameter logic [31:0] RESET_PC      = 32'h0,
   parameter bit          HALT_ON_UNDEF = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] inst,
   input  logic        inst_valid,
   output logic [31:0] pc,
   input  logic [31:0] inM,
   input  logic        mem_ready,
   output logic [31:0] outM,
   output logic        writeM,
   output logic        readM,
   output logic [31:0] addressM,
   output logic        halted
);

   if (ARCH != 32) begin : g_bad_arch
      $fatal(1, "arm_mc_core: ARCH must be 32");
   end

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, addr_q, addr_d, outm_q, outm_d;
   logic [3:0]  nzcv_q, nzcv_d;
   logic [31:0] regs_q [0:14];
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [3:0]  rn_idx, rd_idx, rm_idx;
   logic [31:0] rn_val, rd_val, rm_val, pc_plus4, pc_plus8;
   logic [31:0] alu_result;
   logic [3:0]  alu_nzcv;
   logic        is_dp, is_ls, is_br, is_undef, is_test;

   assign rn_idx   = ir_q[F_RN +: 4];
   assign rd_idx   = ir_q[F_RD +: 4];
   assign rm_idx   = ir_q[F_RM +: 4];
   assign pc_plus4 = pc_q + 32'd4;
   assign pc_plus8 = pc_q + 32'd8;
   assign rn_val   = (rn_idx == 4'd15) ? pc_plus8 : regs_q[rn_idx];
   assign rd_val   = (rd_idx == 4'd15) ? pc_plus8 : regs_q[rd_idx];
   assign rm_val   = (rm_idx == 4'd15) ? pc_plus8 : regs_q[rm_idx];

   // Register-specified shifts (and the multiply/swap space) have bit 4 set with I=0
   assign is_dp    = (ir_q[27:26] == 2'b00) && (ir_q[B_I] || !ir_q[B_REGSH]);
   assign is_ls    = (ir_q[27:26] == 2'b01) && !ir_q[B_I] && ir_q[B_P] && !ir_q[B_B] && !ir_q[B_W];
   assign is_br    = (ir_q[27:25] == 3'b101);
   assign is_undef = (ir_q[F_COND +: 4] == COND_NV) || !(is_dp || is_ls || is_br);
   assign is_test  = (ir_q[24:23] == 2'b10);

   arm_alu u_alu (
      .opcode      (ir_q[24:21]),
      .imm_op      (ir_q[B_I]),
      .imm8        (ir_q[7:0]),
      .shift_field (ir_q[11:5]),
      .rn_val      (rn_val),
      .rm_val      (rm_val),
      .c_in        (nzcv_q[1]),
      .v_in        (nzcv_q[0]),
      .result      (alu_result),
      .nzcv_out    (alu_nzcv)
   );

   // Next-state, pc, flag and register-write decisions
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      addr_d   = addr_q;
      outm_d   = outm_q;
      nzcv_d   = nzcv_q;
      rf_we    = 1'b0;
      rf_waddr = rd_idx;
      rf_wdata = alu_result;
      case (state_q)
         FETCH: begin
            if (inst_valid) begin
               ir_d    = inst;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            pc_d    = pc_plus4;
            if (is_undef) begin
               if (HALT_ON_UNDEF) begin
                  state_d = HALT;
                  pc_d    = pc_q;
               end
            end else if (!cond_pass(ir_q[F_COND +: 4], nzcv_q)) begin
               pc_d = pc_plus4;
            end else if (is_dp) begin
               if (ir_q[B_S] || is_test) nzcv_d = alu_nzcv;
               if (!is_test) begin
                  if (rd_idx == 4'd15) pc_d = {alu_result[31:2], 2'b00};
                  else                 rf_we = 1'b1;
               end
            end else if (is_ls) begin
               addr_d  = ir_q[B_U] ? rn_val + {20'd0, ir_q[11:0]} : rn_val - {20'd0, ir_q[11:0]};
               outm_d  = rd_val;
               pc_d    = pc_q;
               state_d = MEM;
            end else begin
               pc_d = pc_plus8 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
               if (ir_q[B_LINK]) begin
                  rf_we    = 1'b1;
                  rf_waddr = 4'd14;
                  rf_wdata = pc_plus4;
               end
            end
         end
         MEM: begin
            if (mem_ready) begin
               state_d = FETCH;
               pc_d    = pc_plus4;
               if (ir_q[B_L]) begin
                  if (rd_idx == 4'd15) begin
                     pc_d = {inM[31:2], 2'b00};
                  end else begin
                     rf_we    = 1'b1;
                     rf_wdata = inM;
                  end
               end
            end
         end
         HALT: ;
         default: state_d = FETCH;
      endcase
   end

   // Architectural and control state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         addr_q  <= '0;
         outm_q  <= '0;
         nzcv_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         addr_q  <= addr_d;
         outm_q  <= outm_d;
         nzcv_q  <= nzcv_d;
      end
   end

   // General registers R0-R14, single write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      end else if (rf_we) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

   assign pc       = pc_q;
   assign readM    = (state_q == MEM) && ir_q[B_L];
   assign writeM   = (state_q == MEM) && !ir_q[B_L];
   assign addressM = addr_q;
   assign outM     = outm_q;
   assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_arm_mc_core.sv
// Directed-vector bench for arm_mc_core; a second instance runs with
// HALT_ON_UNDEF=0 on the same stimulus.
module tb_arm_mc_core;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] inst = '0;
   logic        inst_valid = 1'b0;
   logic [31:0] inM = '0;
   logic        mem_ready = 1'b0;

   logic [31:0] pc, outM, addressM;
   logic        writeM, readM, halted;
   logic [31:0] pc_nh, outM_nh, addressM_nh;
   logic        writeM_nh, readM_nh, halted_nh;

   int          n_run = 0;
   int          n_fail = 0;
   logic [31:0] cur_pc;

   always #5 clk = ~clk;

   arm_mc_core #(.ARCH(32), .RESET_PC(32'h0), .HALT_ON_UNDEF(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .inst(inst), .inst_valid(inst_valid), .pc(pc),
      .inM(inM), .mem_ready(mem_ready), .outM(outM), .writeM(writeM), .readM(readM),
      .addressM(addressM), .halted(halted)
   );

   arm_mc_core #(.ARCH(32), .RESET_PC(32'h0), .HALT_ON_UNDEF(1'b0)) dut_nh (
      .clk(clk), .reset_n(reset_n), .inst(inst), .inst_valid(inst_valid), .pc(pc_nh),
      .inM(inM), .mem_ready(mem_ready), .outM(outM_nh), .writeM(writeM_nh), .readM(readM_nh),
      .addressM(addressM_nh), .halted(halted_nh)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Data-processing or branch: two cycles, pc held during EXEC
   task automatic dp(input string tag, input logic [31:0] word, input logic [31:0] next_pc);
      inst = word;
      inst_valid = 1'b1;
      @(negedge clk);
      inst_valid = 1'b0;
      chk({tag, "_exec_pc"}, pc, cur_pc);
      @(negedge clk);
      chk({tag, "_pc"}, pc, next_pc);
      cur_pc = next_pc;
   endtask

   // Load/store with a given number of mem_ready-low cycles in MEM
   task automatic ls(input string tag, input logic [31:0] word, input bit is_load,
                     input logic [31:0] exp_addr, input logic [31:0] exp_data,
                     input logic [31:0] ld_data, input int stalls);
      inst = word;
      inst_valid = 1'b1;
      @(negedge clk);
      inst_valid = 1'b0;
      mem_ready = 1'b0;
      chk({tag, "_exec_strb"}, {30'd0, readM, writeM}, 32'd0);
      @(negedge clk);
      for (int i = 0; i <= stalls; i++) begin
         chk({tag, "_strb"}, {30'd0, readM, writeM}, is_load ? 32'd2 : 32'd1);
         chk({tag, "_addr"}, addressM, exp_addr);
         if (!is_load) chk({tag, "_data"}, outM, exp_data);
         chk({tag, "_mem_pc"}, pc, cur_pc);
         if (i == stalls) begin
            mem_ready = 1'b1;
            inM = ld_data;
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      chk({tag, "_done_strb"}, {30'd0, readM, writeM}, 32'd0);
      chk({tag, "_pc"}, pc, cur_pc + 32'd4);
      cur_pc = cur_pc + 32'd4;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cur_pc = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_strb", {30'd0, readM, writeM}, 32'd0);
      chk("rst_addr", addressM, 32'h0);
      chk("rst_outm", outM, 32'h0);
      chk("rst_halted", halted, 32'd0);
      chk("rst_nzcv", {28'd0, dut.nzcv_q}, 32'h0);
      chk("rst_nh_strb", {30'd0, readM_nh, writeM_nh}, 32'd0);
      chk("rst_nh_bus", addressM_nh | outM_nh, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // inst_valid low: pc stays put in FETCH
      repeat (2) @(negedge clk);
      chk("fetch_stall_pc", pc, 32'h0);

      dp("mov_ff", 32'hE3A000FF, 32'h4);
      dp("adds", 32'hE2901001, 32'h8);
      chk("adds_nzcv", {28'd0, dut.nzcv_q}, 32'h0);
      ls("str_r1", 32'hE5821000, 1'b0, 32'h0, 32'h100, 32'h0, 0);

      dp("mov_0", 32'hE3A00000, 32'hC + 32'h4);
      dp("subs", 32'hE2501001, 32'h14);
      chk("subs_nzcv", {28'd0, dut.nzcv_q}, 32'h8);
      dp("addeq", 32'h02802005, 32'h18);
      ls("str_r2", 32'hE5802000, 1'b0, 32'h0, 32'h0, 32'h0, 0);
      ls("str_r1b", 32'hE5801000, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 0);

      dp("bl", 32'hEB000002, 32'h30);
      dp("mov_100", 32'hE3A00C01, 32'h34);
      ls("str_stall", 32'hE5801004, 1'b0, 32'h104, 32'hFFFF_FFFF, 32'h0, 3);
      ls("str_lr", 32'hE500E008, 1'b0, 32'hF8, 32'h24, 32'h0, 0);
      ls("ldr_r3", 32'hE5903004, 1'b1, 32'h104, 32'h0, 32'hDEAD_BEEF, 1);
      ls("str_r3", 32'hE5803000, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);

      dp("movs_lsr0", 32'hE1B04021, 32'h48);
      chk("lsr32_nzcv", {28'd0, dut.nzcv_q}, 32'h6);
      dp("movs_rrx", 32'hE1B05061, 32'h4C);
      chk("rrx_nzcv", {28'd0, dut.nzcv_q}, 32'hA);
      ls("str_r5", 32'hE5805000, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 0);
      dp("mvn", 32'hE3E07102, 32'h54);
      dp("adds_ovf", 32'hE2978001, 32'h58);
      chk("ovf_nzcv", {28'd0, dut.nzcv_q}, 32'h9);
      dp("add_pc", 32'hE280F003, 32'h100);
      dp("sub_r15", 32'hE24F9000, 32'h104);
      ls("str_r9", 32'hE5809000, 1'b0, 32'h100, 32'h108, 32'h0, 0);

      // MUL encoding: halts one instance, NOP in the other
      inst = 32'hE0000091;
      inst_valid = 1'b1;
      @(negedge clk);
      inst_valid = 1'b0;
      @(negedge clk);
      chk("undef_halted", halted, 32'd1);
      chk("undef_pc", pc, 32'h108);
      chk("undef_nop_pc", pc_nh, 32'h10C);
      chk("undef_nop_halted", halted_nh, 32'd0);
      inst = 32'hE1A00000;
      inst_valid = 1'b1;
      repeat (4) @(negedge clk);
      chk("halt_hold_pc", pc, 32'h108);
      chk("halt_hold", halted, 32'd1);
      inst_valid = 1'b0;

      reset_n = 1'b0;
      #1;
      chk("rst2_halted", halted, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst2_pc", pc, 32'h0);

      // Reset arriving mid-MEM drops the strobe without a clock edge
      inst = 32'hE5903004;
      inst_valid = 1'b1;
      @(negedge clk);
      inst_valid = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("mid_mem_readM", readM, 32'd1);
      chk("mid_mem_addr", addressM, 32'h4);
      #2 reset_n = 1'b0;
      #1;
      chk("async_readM", readM, 32'd0);
      chk("async_addr", addressM, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst3_pc", pc, 32'h0);
      chk("rst3_strb", {30'd0, readM, writeM}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
